// File: rtl/eth_tx_pkg.sv
// Shared encodings and constants for the GMII transmit framer.
// Holds the FSM state type, the framing bytes and the CRC-32 byte-step function.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAD  = 3'd3,
        S_FCS  = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    localparam logic [7:0]  PREAMBLE = 8'h55;
    localparam logic [7:0]  SFD      = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam int          PRE_LEN  = 8;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Byte-wide CRC-32 accumulator; exposes the raw (uncomplemented) state.
// init has priority over en; the register holds when neither is asserted.
module crc32_byte
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC state: restart, fold one byte, or hold.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_next(crc_q, d);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, client payload via tx_warn look-ahead,
// zero pad to minimum length, CRC-32 FCS and inter-frame gap.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int JUMBO_DW = 14,
    parameter int MIN_LEN  = 60,
    parameter int IFG      = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_req,
    input  logic [JUMBO_DW-1:0] tx_len,
    output logic                tx_ack,
    output logic                tx_warn,
    input  logic [7:0]          tx_data,
    output logic [7:0]          gmii_txd,
    output logic                gmii_tx_en,
    output logic                busy
);

    localparam logic [JUMBO_DW-1:0] PRE_LAST   = JUMBO_DW'(PRE_LEN - 1);
    localparam logic [JUMBO_DW-1:0] WARN_START = JUMBO_DW'(PRE_LEN - 2);
    localparam logic [JUMBO_DW-1:0] MIN_LEN_W  = JUMBO_DW'(MIN_LEN);
    localparam logic [JUMBO_DW-1:0] MIN_LAST   = JUMBO_DW'(MIN_LEN - 1);
    localparam logic [JUMBO_DW-1:0] IFG_LAST   = JUMBO_DW'(IFG - 1);
    localparam logic [JUMBO_DW-1:0] FCS_LAST   = JUMBO_DW'(3);
    localparam logic [JUMBO_DW-1:0] CNT_ONE    = JUMBO_DW'(1);
    localparam logic [JUMBO_DW-1:0] CNT_ZERO   = {JUMBO_DW{1'b0}};

    state_t              state_q, state_d;
    logic [JUMBO_DW-1:0] cnt_q, cnt_d;
    logic [JUMBO_DW-1:0] len_q, len_d;
    logic                ack_q, ack_d;
    logic                warn_q, warn_d;
    logic [7:0]          txd_q, txd_d;
    logic                en_q, en_d;
    logic                busy_q;

    logic                crc_init_s;
    logic                crc_en_s;
    logic [7:0]          crc_byte_s;
    logic [31:0]         crc_s;
    logic [31:0]         fcs_s;
    logic [JUMBO_DW:0]   cnt_plus2_s;

    crc32_byte u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init_s),
        .en    (crc_en_s),
        .d     (crc_byte_s),
        .crc   (crc_s)
    );

    assign fcs_s       = ~crc_s;
    // Extra bit so a maximum-length frame cannot wrap the look-ahead compare.
    assign cnt_plus2_s = {1'b0, cnt_q} + (JUMBO_DW + 1)'(2);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ack_d      = 1'b0;
        warn_d     = 1'b0;
        txd_d      = 8'h00;
        en_d       = 1'b0;
        crc_init_s = 1'b0;
        crc_en_s   = 1'b0;
        crc_byte_s = tx_data;
        case (state_q)
            S_IDLE: begin
                // ack_q blocks a re-accept while the client is still dropping tx_req.
                if (tx_req && !ack_q) begin
                    ack_d = 1'b1;
                    len_d = tx_len;
                    if (tx_len != CNT_ZERO) begin
                        state_d = S_PRE;
                        cnt_d   = CNT_ONE;
                        txd_d   = PREAMBLE;
                        en_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                en_d       = 1'b1;
                crc_init_s = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    txd_d   = SFD;
                    warn_d  = (len_q > CNT_ONE);
                    state_d = S_DATA;
                    cnt_d   = CNT_ZERO;
                end else begin
                    txd_d  = PREAMBLE;
                    warn_d = (cnt_q == WARN_START);
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                en_d     = 1'b1;
                txd_d    = tx_data;
                crc_en_s = 1'b1;
                warn_d   = (cnt_plus2_s < {1'b0, len_q});
                if (cnt_q == (len_q - CNT_ONE)) begin
                    if (len_q < MIN_LEN_W) begin
                        state_d = S_PAD;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        state_d = S_FCS;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PAD: begin
                en_d       = 1'b1;
                txd_d      = 8'h00;
                crc_en_s   = 1'b1;
                crc_byte_s = 8'h00;
                if (cnt_q == MIN_LAST) begin
                    state_d = S_FCS;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FCS: begin
                en_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    txd_d = fcs_s[7:0];
                    2'd1:    txd_d = fcs_s[15:8];
                    2'd2:    txd_d = fcs_s[23:16];
                    2'd3:    txd_d = fcs_s[31:24];
                    default: txd_d = 8'h00;
                endcase
                if (cnt_q == FCS_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_GAP;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and starts a full gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_GAP;
            cnt_q   <= CNT_ZERO;
            len_q   <= CNT_ZERO;
            ack_q   <= 1'b0;
            warn_q  <= 1'b0;
            txd_q   <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ack_q   <= ack_d;
            warn_q  <= warn_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign tx_ack     = ack_q;
    assign tx_warn    = warn_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_en = en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer and its crc32_byte unit.
module tb_eth_tx_framer;

    localparam int IFG  = 12;
    localparam int MINL = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_req;
    logic [13:0] tx_len;
    logic        tx_ack;
    logic        tx_warn;
    logic [7:0]  tx_data;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        busy;

    logic        c_init, c_en;
    logic [7:0]  c_d;
    logic [31:0] c_crc;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ack_total = 0;
    int ack_cyc_last = -1;
    int fr_cur = 0;
    int ptr = 0;
    int warn_cnt = 0;
    int warn_first = -1;
    int idle_bad = 0;
    bit prev_warn = 1'b0;
    bit prev_ack = 1'b0;
    bit prev_en = 1'b0;
    logic [7:0] wire_q[$];
    logic [7:0] exp_q[$];
    int rise_q[$];
    int fall_q[$];

    eth_tx_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_req     (tx_req),
        .tx_len     (tx_len),
        .tx_ack     (tx_ack),
        .tx_warn    (tx_warn),
        .tx_data    (tx_data),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .busy       (busy)
    );

    crc32_byte u_crc_unit (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (c_init),
        .en    (c_en),
        .d     (c_d),
        .crc   (c_crc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] pay(input int fr, input int k);
        int v;
        v = fr * 49 + k;
        return v[7:0];
    endfunction

    // Bit-serial reference FCS (already complemented).
    function automatic logic [31:0] model_fcs(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input int len, input int fr);
        logic [7:0]  body[$];
        logic [31:0] f;
        int          m;
        m = (len < MINL) ? MINL : len;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < m; k++) body.push_back((k < len) ? pay(fr, k) : 8'h00);
        f = model_fcs(body);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int b = 0; b < 4; b++) exp_q.push_back(f[8*b +: 8]);
    endtask

    // One clock: client behaviour plus capture of everything observed on the outputs.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_warn) begin
            tx_data = pay(fr_cur, ptr);
            ptr++;
        end
        if (tx_ack) begin
            fr_cur       = ack_total;
            ack_total++;
            ack_cyc_last = cyc;
            ptr          = 0;
        end
        if (tx_warn) begin
            if (warn_cnt == 0) warn_first = cyc;
            warn_cnt++;
        end
        if (gmii_tx_en) begin
            wire_q.push_back(gmii_txd);
            if (!prev_en) rise_q.push_back(cyc);
        end else begin
            if (gmii_txd !== 8'h00) idle_bad++;
            if (prev_en) fall_q.push_back(cyc - 1);
        end
        if (prev_ack) tx_req = 1'b0;
        prev_ack  = tx_ack;
        prev_warn = tx_warn;
        prev_en   = gmii_tx_en;
    endtask

    task automatic clear_capture();
        wire_q.delete();
        exp_q.delete();
        rise_q.delete();
        fall_q.delete();
        warn_cnt   = 0;
        warn_first = -1;
    endtask

    task automatic compare_bytes(input string tag);
        chk({tag, "_nbytes"}, wire_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'd0, wire_q[i]}, {24'd0, exp_q[i]});
    endtask

    // Runs until the accepted frame and its gap are over; t0 is the cycle IDLE saw tx_req.
    task automatic finish_frame(input int len, input int fr, input int t0, input string tag);
        bit done;
        int m;
        done = 1'b0;
        for (int i = 0; i < len + 300; i++) begin
            step();
            if (ack_cyc_last > t0 && !busy && cyc > t0 + 3) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_acks"}, ack_total - fr, 32'd1);
        chk({tag, "_ack_t"}, ack_cyc_last - t0, 32'd1);
        if (len == 0) begin
            chk({tag, "_rises"}, rise_q.size(), 32'd0);
            chk({tag, "_warns"}, warn_cnt, 32'd0);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        end else begin
            m = (len < MINL) ? MINL : len;
            build_exp(len, fr);
            chk({tag, "_rises"}, rise_q.size(), 32'd1);
            chk({tag, "_falls"}, fall_q.size(), 32'd1);
            if (rise_q.size() > 0 && fall_q.size() > 0) begin
                chk({tag, "_rise_t"}, rise_q[0] - t0, 32'd1);
                chk({tag, "_en_len"}, fall_q[0] - rise_q[0] + 1, 12 + m);
                chk({tag, "_idle_t"}, cyc - fall_q[0], IFG);
            end
            chk({tag, "_warns"}, warn_cnt, len);
            chk({tag, "_warn_t"}, warn_first - t0, 32'd7);
            compare_bytes(tag);
        end
    endtask

    task automatic run_frame(input int len, input string tag);
        int fr;
        int t0;
        clear_capture();
        chk({tag, "_pre_busy"}, {31'd0, busy}, 32'd0);
        fr     = ack_total;
        t0     = cyc;
        tx_len = 14'(len);
        tx_req = 1'b1;
        finish_frame(len, fr, t0, tag);
    endtask

    initial begin
        int fr;
        int t0;
        int rcyc;
        bit done;
        logic [31:0] fin;

        rst_n   = 1'b0;
        tx_req  = 1'b0;
        tx_len  = 14'd0;
        tx_data = 8'h00;
        c_init  = 1'b0;
        c_en    = 1'b0;
        c_d     = 8'h00;

        step();
        step();
        chk("rst_en", {31'd0, gmii_tx_en}, 32'd0);
        chk("rst_txd", {24'd0, gmii_txd}, 32'd0);
        chk("rst_ack", {31'd0, tx_ack}, 32'd0);
        chk("rst_warn", {31'd0, tx_warn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < IFG - 1; i++) step();
        chk("gap_busy_last", {31'd0, busy}, 32'd1);
        step();
        chk("gap_busy_idle", {31'd0, busy}, 32'd0);

        // CRC unit on the standard check string.
        c_init = 1'b1;
        step();
        c_init = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c_en = 1'b1;
            c_d  = 8'(8'h31 + i);
            step();
        end
        c_en = 1'b0;
        fin  = ~c_crc;
        chk("crc_check", fin, 32'hCBF43926);
        chk("crc_ser0", {24'd0, fin[7:0]}, 32'h26);
        chk("crc_ser1", {24'd0, fin[15:8]}, 32'h39);
        chk("crc_ser2", {24'd0, fin[23:16]}, 32'hF4);
        chk("crc_ser3", {24'd0, fin[31:24]}, 32'hCB);

        run_frame(64, "f64");
        run_frame(10, "f10");
        run_frame(0, "zero");
        run_frame(1, "f1");
        run_frame(60, "f60");

        // Back-to-back: second request raised right after the first ack.
        clear_capture();
        fr     = ack_total;
        t0     = cyc;
        tx_len = 14'd20;
        tx_req = 1'b1;
        step();
        chk("b2b_ack1_t", ack_cyc_last - t0, 32'd1);
        step();
        step();
        tx_req = 1'b1;
        tx_len = 14'd70;
        done   = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (ack_total == fr + 2 && !busy && cyc > ack_cyc_last + 3) begin
                done = 1'b1;
                break;
            end
        end
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_rises", rise_q.size(), 32'd2);
        chk("b2b_falls", fall_q.size(), 32'd2);
        if (rise_q.size() == 2 && fall_q.size() == 2) begin
            chk("b2b_ack2_t", ack_cyc_last - fall_q[0], IFG + 1);
            chk("b2b_idle", rise_q[1] - fall_q[0] - 1, IFG);
        end
        build_exp(20, fr);
        build_exp(70, fr + 1);
        compare_bytes("b2b");

        // Reset at payload byte 20 of a 100-byte frame, request left pending.
        clear_capture();
        fr     = ack_total;
        t0     = cyc;
        tx_len = 14'd100;
        tx_req = 1'b1;
        for (int i = 0; i < 29; i++) step();
        chk("mid_b20", {24'd0, gmii_txd}, {24'd0, pay(fr, 20)});
        rst_n  = 1'b0;
        tx_req = 1'b1;
        tx_len = 14'd100;
        step();
        rst_n = 1'b1;
        rcyc  = cyc;
        chk("mid_rst_en", {31'd0, gmii_tx_en}, 32'd0);
        chk("mid_rst_txd", {24'd0, gmii_txd}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd1);
        chk("mid_rst_warn", {31'd0, tx_warn}, 32'd0);
        chk("mid_rst_ack", {31'd0, tx_ack}, 32'd0);
        clear_capture();
        finish_frame(100, ack_total, rcyc + IFG, "mid_refr");

        run_frame(16383, "jumbo");

        chk("idle_txd_zero", idle_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit-side framer between a packet client and the GMII byte interface. Arbitrates nothing (single client); accepts one frame request at a time via `tx_req`/`tx_ack`. Pulls payload bytes from the client using the `tx_warn` look-ahead strobe, and emits preamble, SFD, payload, zero padding to minimum length, CRC-32 FCS, then enforces the inter-frame gap. Sits directly downstream of ping-pong-buffered clients that drive `tx_req`, `tx_len` and a read-latency-1 `data_out`.

## Interface
- `jumbo_dw`, 14, width of `tx_len` (14 jumbo, 11 standard)
- `min_len`, 60, minimum payload+pad byte count before FCS
- `ifg`, 12, idle cycles (`gmii_tx_en`=0) after last FCS byte

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `tx_req`  in  1  client has a frame ready; held until `tx_ack`
- `tx_len`  in  jumbo_dw  payload byte count; stable while `tx_req`=1
- `tx_ack`  out  1  one-cycle pulse: request accepted, `tx_len` latched
- `tx_warn`  out  1  high for exactly `len` cycles, one cycle before each byte is sampled
- `tx_data`  in  8  client byte, valid the cycle after the matching `tx_warn` cycle
- `gmii_txd`  out  8  registered transmit byte
- `gmii_tx_en`  out  1  registered frame-valid
- `busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, PRE, DATA, PAD, FCS, GAP.
- IDLE: on `tx_req`=1 → pulse `tx_ack`, latch `len`=`tx_len`, go PRE. If latched `len`=0 → pulse `tx_ack` only, go IDLE, nothing transmitted, no `tx_warn`.
- PRE: 7 bytes 0x55 then 1 byte 0xD5; 8 cycles total.
- DATA: `len` bytes copied from `tx_data`; each byte folded into CRC.
- PAD: if `len` < `min_len`, (`min_len`−`len`) bytes 0x00, folded into CRC; skipped otherwise.
- FCS: 4 bytes, CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement), least-significant byte first.
- GAP: `gmii_tx_en`=0, `gmii_txd`=0 for `ifg` cycles, then IDLE. `tx_req` ignored outside IDLE.
- Byte counter width `jumbo_dw`; `len`=2^jumbo_dw−1 legal, counter must not wrap early.
- Reset (any state, incl. mid-frame): next edge `gmii_tx_en`=0, `gmii_txd`=0, `tx_ack`=0, `tx_warn`=0, `busy`=1, state GAP with full `ifg` count. A truncated frame is abandoned, never resumed; a pending `tx_req` is accepted after the gap.

## Timing
- Reset values: all outputs 0 except `busy`=1 (in GAP).
- Cycle T0: IDLE samples `tx_req`=1. T1: `tx_ack`=1; `gmii_tx_en`=1, `gmii_txd`=0x55.
- T1–T7: 0x55 on wire; T8: 0xD5.
- `tx_warn` high T7 … T7+len−1; `tx_data` sampled T8+k for byte k; byte k on wire T9+k.
- Pad bytes follow immediately, then FCS; no idle cycles inside a frame.
- Frame on wire ends at T8+max(len,`min_len`)+4; GAP follows; earliest next `tx_ack` is `ifg`+1 cycles after last FCS byte.
- Client drops `tx_req` one cycle after `tx_ack` (registered); `tx_req` still high at T1/T2 must not cause a second accept.
- `len`=0 drop: `tx_ack` at T1, IDLE again at T1; next accept no earlier than T2.

## Structure
- Package `eth_tx_pkg`: state encoding, PREAMBLE=0x55, SFD=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, PRE_LEN=8.
- Sub-module `crc32_byte`: one byte per cycle, inputs `init`, `en`, `d[7:0]`, output `crc[31:0]` (uncomplemented state); framer complements and serializes.
- Top-level FSM plus byte counter, `tx_warn` generator, output registers.

## Test plan
- `crc32_byte` unit: bytes "123456789" after init → complemented result 0xCBF43926, serialized 0x26,0x39,0xF4,0xCB.
- `tx_len`=64, payload 0x00..0x3F → 8 preamble/SFD, 64 bytes in order, no pad, 4 FCS matching software model; `tx_warn` exactly 64 cycles, starting T7.
- `tx_len`=10 → 10 payload bytes, 50 bytes 0x00, FCS over 60 bytes; `gmii_tx_en` high 72 cycles contiguous.
- Back-to-back: `tx_req` re-asserted immediately after ack → second `tx_ack` exactly `ifg`+1 cycles after first frame's last FCS byte; exactly 12 idle cycles between frames.
- `tx_len`=0 → single `tx_ack`, `gmii_tx_en` never rises, `tx_warn` never rises.
- `rst_n` low for one cycle at payload byte 20 of a 100-byte frame → `gmii_tx_en`=0 next edge; 12 idle cycles; pending request re-acked; new frame complete and FCS-correct.
